// File: rtl/accum_readout_pkg.sv
// Shared FSM states, channel IDs and frame-length helper for the readout scheduler.
// READOUT_PARITY_EN adds one trailing even-parity bit to every frame.
package accum_readout_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_GAP   = 2'd2
  } state_t;

  localparam logic CH_SA  = 1'b0;
  localparam logic CH_CML = 1'b1;

`ifdef READOUT_PARITY_EN
  localparam int PARITY_BITS = 1;
`else
  localparam int PARITY_BITS = 0;
`endif

  // One header bit, the word, then the optional parity bit.
  function automatic int frame_len(input int acc_width);
    return acc_width + 1 + PARITY_BITS;
  endfunction

endpackage

// File: rtl/readout_shifter.sv
// Loadable MSB-first shift register with a bit counter and a last-bit flag.
module readout_shifter #(
  parameter int WIDTH = 17,
  parameter int CW    = 5
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             i_load,
  input  logic [WIDTH-1:0] i_data,
  input  logic             i_shift,
  output logic             o_bit,
  output logic [CW-1:0]    o_count,
  output logic             o_done
);

  logic [WIDTH-1:0] r_data;
  logic [CW-1:0]    r_count;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_data  <= '0;
      r_count <= '0;
    end else if (i_load) begin
      r_data  <= i_data;
      r_count <= '0;
    end else if (i_shift) begin
      r_data  <= {r_data[WIDTH-2:0], 1'b0};
      r_count <= r_count + CW'(1);
    end
  end

  assign o_bit   = r_data[WIDTH-1];
  assign o_count = r_count;
  assign o_done  = (r_count == CW'(WIDTH - 1));

endmodule

// File: rtl/accum_readout_scheduler.sv
// Round-robin arbiter + framing FSM sharing one serial pad between SA and CML words.
// Define READOUT_PARITY_EN to append an even-parity bit to each frame.
module accum_readout_scheduler
  import accum_readout_pkg::*;
#(
  parameter int ACC_WIDTH  = 16,
  parameter int GAP_CYCLES = 1
) (
  input  logic                 i_clk,
  input  logic                 i_reset,
  input  logic                 i_enable,
  input  logic [ACC_WIDTH-1:0] i_sa_word,
  input  logic                 i_sa_valid,
  output logic                 o_sa_ack,
  input  logic [ACC_WIDTH-1:0] i_cml_word,
  input  logic                 i_cml_valid,
  output logic                 o_cml_ack,
  output logic                 o_serial_start,
  output logic                 o_serial_out,
  output logic                 o_busy
);

  localparam int FRAME_LEN = frame_len(ACC_WIDTH);
  localparam int CW        = $clog2(FRAME_LEN + 1);
  localparam int GW        = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam int GAP_LAST  = (GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0;

  state_t                 r_state;
  state_t                 w_next;
  logic                   r_rr_last;
  logic [GW-1:0]          r_gap_cnt;
  logic                   r_sa_ack;
  logic                   r_cml_ack;
  logic                   r_serial_start;
  logic                   r_serial_out;
  logic                   r_busy;
  logic                   w_load;
  logic                   w_shift;
  logic                   w_grant_id;
  logic [ACC_WIDTH-1:0]   w_word;
  logic [FRAME_LEN-1:0]   w_frame;
  logic                   w_bit;
  logic [CW-1:0]          w_count;
  logic                   w_done;

  // Ties go to whichever channel was not served last.
  assign w_grant_id = (i_sa_valid && i_cml_valid) ? ~r_rr_last
                    : (i_sa_valid ? CH_SA : CH_CML);
  assign w_word     = (w_grant_id == CH_CML) ? i_cml_word : i_sa_word;

`ifdef READOUT_PARITY_EN
  assign w_frame = {w_grant_id, w_word, ^{w_grant_id, w_word}};
`else
  assign w_frame = {w_grant_id, w_word};
`endif

  readout_shifter #(
    .WIDTH (FRAME_LEN),
    .CW    (CW)
  ) u_shifter (
    .i_clk   (i_clk),
    .i_reset (i_reset),
    .i_load  (w_load),
    .i_data  (w_frame),
    .i_shift (w_shift),
    .o_bit   (w_bit),
    .o_count (w_count),
    .o_done  (w_done)
  );

  always_comb begin
    w_next  = r_state;
    w_load  = 1'b0;
    w_shift = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (i_enable && (i_sa_valid || i_cml_valid)) begin
          w_load = 1'b1;
          w_next = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        w_shift = 1'b1;
        if (w_done) begin
          w_next = (GAP_CYCLES > 0) ? ST_GAP : ST_IDLE;
        end
      end
      ST_GAP: begin
        if (r_gap_cnt == GW'(GAP_LAST)) begin
          w_next = ST_IDLE;
        end
      end
      default: w_next = ST_IDLE;
    endcase
  end

  // Busy covers the ack cycle through the last gap cycle seen on the pad.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state        <= ST_IDLE;
      r_rr_last      <= CH_CML;
      r_gap_cnt      <= '0;
      r_sa_ack       <= 1'b0;
      r_cml_ack      <= 1'b0;
      r_serial_start <= 1'b0;
      r_serial_out   <= 1'b0;
      r_busy         <= 1'b0;
    end else begin
      r_state        <= w_next;
      r_sa_ack       <= w_load && (w_grant_id == CH_SA);
      r_cml_ack      <= w_load && (w_grant_id == CH_CML);
      r_serial_start <= w_shift && (w_count == '0);
      r_serial_out   <= w_shift && w_bit;
      r_busy         <= (w_next != ST_IDLE) || (r_state != ST_IDLE);
      if (w_load) begin
        r_rr_last <= w_grant_id;
      end
      if (r_state == ST_GAP) begin
        r_gap_cnt <= r_gap_cnt + GW'(1);
      end else begin
        r_gap_cnt <= '0;
      end
    end
  end

  assign o_sa_ack       = r_sa_ack;
  assign o_cml_ack      = r_cml_ack;
  assign o_serial_start = r_serial_start;
  assign o_serial_out   = r_serial_out;
  assign o_busy         = r_busy;

endmodule

// File: tb/tb_accum_readout_scheduler.sv
// Self-checking bench for accum_readout_scheduler: directed scenarios then random traffic,
// compared cycle by cycle against a transaction-level timing model; a GAP_CYCLES=0 copy runs alongside.
module tb_accum_readout_scheduler;

  localparam int W = 16;
  localparam int G = 1;
`ifdef READOUT_PARITY_EN
  localparam int F = W + 2;
`else
  localparam int F = W + 1;
`endif

  logic         clk;
  logic         reset;
  logic         enable;
  logic [W-1:0] saWord;
  logic         saValid;
  logic         saAck;
  logic [W-1:0] cmlWord;
  logic         cmlValid;
  logic         cmlAck;
  logic         serialStart;
  logic         serialOut;
  logic         busy;

  logic         zReset;
  logic         zSaAck;
  logic         zCmlAck;
  logic         zStart;
  logic         zOut;
  logic         zBusy;
  logic         zDone;

  int errorCount = 0;
  int checkCount = 0;

  int           cyc         = 0;
  int           ackCycle    = -1000;
  int           frameStart  = -1000;
  int           nextAllowed = 0;
  logic         ackCh       = 1'b0;
  logic         rrLast      = 1'b1;
  logic [F-1:0] frameBits   = '0;
  bit           randomMode  = 0;
  bit           contMode    = 0;

  accum_readout_scheduler #(.ACC_WIDTH(W), .GAP_CYCLES(G)) dut (
    .i_clk          (clk),
    .i_reset        (reset),
    .i_enable       (enable),
    .i_sa_word      (saWord),
    .i_sa_valid     (saValid),
    .o_sa_ack       (saAck),
    .i_cml_word     (cmlWord),
    .i_cml_valid    (cmlValid),
    .o_cml_ack      (cmlAck),
    .o_serial_start (serialStart),
    .o_serial_out   (serialOut),
    .o_busy         (busy)
  );

  accum_readout_scheduler #(.ACC_WIDTH(W), .GAP_CYCLES(0)) dutNoGap (
    .i_clk          (clk),
    .i_reset        (zReset),
    .i_enable       (1'b1),
    .i_sa_word      (16'h1234),
    .i_sa_valid     (1'b1),
    .o_sa_ack       (zSaAck),
    .i_cml_word     (16'hFEDC),
    .i_cml_valid    (1'b1),
    .o_cml_ack      (zCmlAck),
    .o_serial_start (zStart),
    .o_serial_out   (zOut),
    .o_busy         (zBusy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checkCount++;
    if (observed !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s: observed %0h expected %0h (cycle %0d)", tag, observed, expected, cyc);
    end
  endtask

  function automatic logic [F-1:0] buildFrame(input logic ch, input logic [W-1:0] word);
`ifdef READOUT_PARITY_EN
    return {ch, word, ^{ch, word}};
`else
    return {ch, word};
`endif
  endfunction

  // Decide, from the inputs about to be sampled, what the next cycle and frame will look like.
  task automatic predictNext();
    logic ch;
    if (reset) begin
      ackCycle    = -1000;
      frameStart  = -1000;
      rrLast      = 1'b1;
      nextAllowed = cyc + 2;
    end else if (enable && (saValid || cmlValid) && (cyc + 1 >= nextAllowed)) begin
      ch          = (saValid && cmlValid) ? ~rrLast : cmlValid;
      ackCh       = ch;
      ackCycle    = cyc + 1;
      frameStart  = cyc + 2;
      frameBits   = buildFrame(ch, ch ? cmlWord : saWord);
      rrLast      = ch;
      nextAllowed = cyc + 1 + F + G + 1;
    end
  endtask

  task automatic checkCycle();
    logic eSa, eCml, eStart, eOut, eBusy;
    int   off;
    eSa    = (cyc == ackCycle) && (ackCh == 1'b0);
    eCml   = (cyc == ackCycle) && (ackCh == 1'b1);
    eStart = (cyc == frameStart);
    off    = cyc - frameStart;
    eOut   = (off >= 0 && off < F) ? frameBits[F-1-off] : 1'b0;
    eBusy  = (cyc >= ackCycle) && (cyc <= ackCycle + F + G);
    checkOutput("sa_ack", 32'(saAck), 32'(eSa));
    checkOutput("cml_ack", 32'(cmlAck), 32'(eCml));
    checkOutput("serial_start", 32'(serialStart), 32'(eStart));
    checkOutput("serial_out", 32'(serialOut), 32'(eOut));
    checkOutput("busy", 32'(busy), 32'(eBusy));
  endtask

  // A requester that has just been acked either withdraws or queues a fresh word.
  task automatic ackReaction();
    if (cyc == ackCycle) begin
      if (ackCh == 1'b0) begin
        if (contMode) saWord = W'($urandom);
        else          saValid = 1'b0;
      end else begin
        if (contMode) cmlWord = W'($urandom);
        else          cmlValid = 1'b0;
      end
    end
  endtask

  task automatic applyStimulus();
    enable = ($urandom_range(0, 9) != 0);
    reset  = ($urandom_range(0, 199) == 0);
    if (!saValid && $urandom_range(0, 3) == 0) begin
      saValid = 1'b1;
      saWord  = W'($urandom);
    end else if (saValid && $urandom_range(0, 39) == 0) begin
      saValid = 1'b0;
    end
    if (!cmlValid && $urandom_range(0, 3) == 0) begin
      cmlValid = 1'b1;
      cmlWord  = W'($urandom);
    end else if (cmlValid && $urandom_range(0, 39) == 0) begin
      cmlValid = 1'b0;
    end
  endtask

  task automatic stepCycle(input int n);
    for (int i = 0; i < n; i++) begin
      predictNext();
      @(negedge clk);
      cyc++;
      checkCycle();
      ackReaction();
      if (randomMode) applyStimulus();
    end
  endtask

  task automatic doReset(input int n);
    reset    = 1'b1;
    saValid  = 1'b0;
    cmlValid = 1'b0;
    stepCycle(n);
    reset    = 1'b0;
  endtask

  // GAP_CYCLES=0 copy: both requests always pending, so headers alternate and starts are F+1 apart.
  initial begin
    int zc, lastStart, starts;
    logic expectHdr;
    zDone     = 1'b0;
    zReset    = 1'b1;
    repeat (3) @(negedge clk);
    zReset    = 1'b0;
    zc        = 0;
    lastStart = -1;
    starts    = 0;
    expectHdr = 1'b0;
    while (starts < 8 && zc < 400) begin
      @(negedge clk);
      zc++;
      if (zStart === 1'b1) begin
        checkOutput("gap0_header", 32'(zOut), 32'(expectHdr));
        expectHdr = ~expectHdr;
        if (lastStart >= 0) checkOutput("gap0_spacing", 32'(zc - lastStart), 32'(F + 1));
        lastStart = zc;
        starts++;
      end
    end
    checkOutput("gap0_frames", 32'(starts), 32'd8);
    zDone = 1'b1;
  end

  initial begin
    int guard;
    reset    = 1'b1;
    enable   = 1'b0;
    saValid  = 1'b0;
    cmlValid = 1'b0;
    saWord   = '0;
    cmlWord  = '0;

    $display("[TB] reset and SA-only frame");
    doReset(3);
    enable  = 1'b1;
    saWord  = 16'hA5C3;
    saValid = 1'b1;
    stepCycle(F + G + 4);

    $display("[TB] simultaneous requests");
    doReset(2);
    saWord   = 16'h5AA5;
    cmlWord  = 16'h0001;
    saValid  = 1'b1;
    cmlValid = 1'b1;
    stepCycle(2 * (F + G + 1) + 4);

    $display("[TB] continuous requests");
    contMode = 1;
    saValid  = 1'b1;
    cmlValid = 1'b1;
    stepCycle(6 * (F + G + 1) + 2);
    contMode = 0;
    saValid  = 1'b0;
    cmlValid = 1'b0;
    stepCycle(F + G + 3);

    $display("[TB] reset mid-frame");
    doReset(2);
    saWord  = 16'h3C5A;
    saValid = 1'b1;
    stepCycle(9);
    reset    = 1'b1;
    saValid  = 1'b1;
    saWord   = 16'h0F0F;
    cmlValid = 1'b1;
    cmlWord  = 16'hF00D;
    stepCycle(1);
    reset = 1'b0;
    stepCycle(2 * (F + G + 1) + 4);

    $display("[TB] enable low");
    enable  = 1'b0;
    saWord  = 16'h8001;
    saValid = 1'b1;
    stepCycle(10);
    enable = 1'b1;
    stepCycle(F + G + 3);
    cmlWord  = 16'h7FFE;
    cmlValid = 1'b1;
    stepCycle(5);
    enable = 1'b0;
    stepCycle(F + G + 6);
    enable = 1'b1;
    stepCycle(3);

    $display("[TB] random traffic");
    randomMode = 1;
    stepCycle(1500);
    randomMode = 0;
    reset = 1'b0;
    stepCycle(2);

    guard = 0;
    while (!zDone && guard < 1000) begin
      @(negedge clk);
      guard++;
    end
    if (!zDone) checkOutput("gap0_timeout", 32'(zDone), 32'd1);

    $display("Result: errors=%0d of %0d checks", errorCount, checkCount);
    $finish;
  end

endmodule
